// File: rtl/clause_batch_feeder_if.sv
// Batch/memory bus between clause_batch_feeder (master) and the clause store plus evaluator cluster (slave).
// Batch handshake: a batch transfers on a cycle with batch_valid_o && batch_ready_i; once valid rises, it and all lane data stay stable until that cycle.
interface clause_batch_feeder_if #(
    parameter int CLUSTER_SIZE = 20,
    parameter int NSAT         = 3,
    parameter int VAR_W        = 8,
    parameter int ADDR_W       = 12
);
    logic [ADDR_W-1:0]             mem_addr_o;
    logic                          mem_en_o;
    logic [NSAT*(VAR_W+1)-1:0]     mem_data_i;
    logic [NSAT*CLUSTER_SIZE-1:0]  var_val_o;
    logic [NSAT*CLUSTER_SIZE-1:0]  var_neg_o;
    logic [CLUSTER_SIZE-1:0]       lane_mask_o;
    logic                          batch_valid_o;
    logic                          batch_ready_i;

    modport master (
        output mem_addr_o, mem_en_o,
        input  mem_data_i,
        output var_val_o, var_neg_o, lane_mask_o, batch_valid_o,
        input  batch_ready_i
    );

    modport slave (
        input  mem_addr_o, mem_en_o,
        output mem_data_i,
        input  var_val_o, var_neg_o, lane_mask_o, batch_valid_o,
        output batch_ready_i
    );
endinterface

// File: rtl/clause_batch_feeder.sv
// Streams a clause range from memory, resolves literals against assign_i and packs lanes into batches.
// Optional CLAUSE_FEEDER_STATS_EN adds batch_cnt_o, a saturating count of batches accepted this range.
module clause_batch_feeder #(
    parameter int CLUSTER_SIZE = 20,
    parameter int NSAT         = 3,
    parameter int NUM_VARS     = 256,
    parameter int VAR_W        = 8,
    parameter int ADDR_W       = 12
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [ADDR_W:0]         count_i,
    input  logic [NUM_VARS-1:0]     assign_i,
    clause_batch_feeder_if.master   bus,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [1:0]              dbg_state_o
`ifdef CLAUSE_FEEDER_STATS_EN
    ,
    output logic [ADDR_W:0]         batch_cnt_o
`endif
);
    localparam int LANE_W = $clog2(CLUSTER_SIZE + 1);
    localparam int VEC_W  = NSAT * CLUSTER_SIZE;
    localparam logic [LANE_W-1:0] CS_L = LANE_W'(CLUSTER_SIZE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [LANE_W-1:0]   fill_q, fill_d;
    logic [LANE_W-1:0]   ret_lane_q, ret_lane_d;
    logic                rd_pending_q, rd_pending_d;
    logic [VEC_W-1:0]    val_q, val_d;
    logic [VEC_W-1:0]    neg_q, neg_d;
    logic [CLUSTER_SIZE-1:0] mask_q, mask_d;
    logic                err_q, err_d;

    logic                issue;
    logic                accept;
    logic                start_ok;
    logic [NSAT-1:0]     ret_val;
    logic [NSAT-1:0]     ret_neg;
    logic                ret_bad;
    logic [VAR_W-1:0]    lit_idx;

    // Literal resolution for the entry returning this cycle; out-of-range indices read as false.
    always_comb begin
        ret_val = '0;
        ret_neg = '0;
        ret_bad = 1'b0;
        lit_idx = '0;
        for (int k = 0; k < NSAT; k++) begin
            lit_idx    = bus.mem_data_i[k*(VAR_W+1) +: VAR_W];
            ret_neg[k] = bus.mem_data_i[k*(VAR_W+1) + VAR_W];
            if (int'(lit_idx) < NUM_VARS) begin
                ret_val[k] = assign_i[lit_idx];
            end else begin
                ret_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        fill_d   = fill_q;
        issue    = 1'b0;
        accept   = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    addr_d   = base_addr_i;
                    remain_d = count_i;
                    fill_d   = '0;
                    state_d  = (count_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                // Leaving FILL on the first non-issue cycle is safe: the last read returns in this same cycle.
                if (fill_q < CS_L && remain_q != '0) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - (ADDR_W+1)'(1);
                    fill_d   = fill_q + LANE_W'(1);
                end else begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.batch_ready_i) begin
                    accept  = 1'b1;
                    fill_d  = '0;
                    state_d = (remain_q == '0) ? DONE : FILL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_pending_d = issue;
        ret_lane_d   = fill_q;
        val_d        = val_q;
        neg_d        = neg_q;
        mask_d       = mask_q;
        err_d        = err_q;
        if (accept) begin
            val_d  = '1;
            neg_d  = '0;
            mask_d = '0;
        end else if (rd_pending_q) begin
            for (int i = 0; i < CLUSTER_SIZE; i++) begin
                if (ret_lane_q == LANE_W'(i)) begin
                    mask_d[i] = 1'b1;
                    for (int k = 0; k < NSAT; k++) begin
                        val_d[i*NSAT+k] = ret_val[k];
                        neg_d[i*NSAT+k] = ret_neg[k];
                    end
                end
            end
        end
        if (start_ok) begin
            err_d = 1'b0;
        end else if (rd_pending_q && ret_bad) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            fill_q       <= '0;
            ret_lane_q   <= '0;
            rd_pending_q <= 1'b0;
            val_q        <= '1;
            neg_q        <= '0;
            mask_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            fill_q       <= fill_d;
            ret_lane_q   <= ret_lane_d;
            rd_pending_q <= rd_pending_d;
            val_q        <= val_d;
            neg_q        <= neg_d;
            mask_q       <= mask_d;
            err_q        <= err_d;
        end
    end

`ifdef CLAUSE_FEEDER_STATS_EN
    logic [ADDR_W:0] batch_cnt_q, batch_cnt_d;

    always_comb begin
        batch_cnt_d = batch_cnt_q;
        if (start_ok) begin
            batch_cnt_d = '0;
        end else if (accept && batch_cnt_q != '1) begin
            batch_cnt_d = batch_cnt_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            batch_cnt_q <= '0;
        end else begin
            batch_cnt_q <= batch_cnt_d;
        end
    end

    assign batch_cnt_o = batch_cnt_q;
`endif

    always_comb begin
        bus.mem_addr_o    = addr_q;
        bus.mem_en_o      = issue;
        bus.var_val_o     = val_q;
        bus.var_neg_o     = neg_q;
        bus.lane_mask_o   = mask_q;
        bus.batch_valid_o = (state_q == PRESENT);
        busy_o            = (state_q != IDLE);
        done_o            = (state_q == DONE);
        err_o             = err_q;
        dbg_state_o       = state_q;
    end
endmodule
